// File: rtl/net_injector.sv
// Per-node transmit front end: assembles beat-serial core packets into network packets,
// queues them, and strobes them into the network node when it reports space.
// Packet layout (MSB..LSB): src[7:0], dest[7:0], len[LEN_W-1:0], data[WORDS-1:0] with word 0 at the LSBs.
module net_injector #(
    parameter int NODE_ID   = 0,
    parameter int NUM_NODES = 8,
    parameter int DATA_W    = 64,
    parameter int WORDS     = 8,
    parameter int Q_DEPTH   = 2,
    localparam int LEN_W    = $clog2(WORDS + 1),
    localparam int PKT_W    = 16 + LEN_W + WORDS * DATA_W
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              core_valid,
    output logic              core_ready,
    input  logic [7:0]        core_dest,
    input  logic [DATA_W-1:0] core_data,
    input  logic              core_last,
    input  logic              net_accept,
    output logic              pkt_valid,
    output logic [PKT_W-1:0]  pkt_out,
    output logic              drop_err,
    output logic [15:0]       sent_cnt
);

    localparam int PTR_W  = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int QCNT_W = $clog2(Q_DEPTH + 1);

    localparam logic [8:0]        NODES_LIM = 9'(NUM_NODES);
    localparam logic [7:0]        SELF_ID   = 8'(NODE_ID);
    localparam logic [LEN_W-1:0]  WORDS_L   = LEN_W'(WORDS);
    localparam logic [QCNT_W-1:0] Q_DEPTH_L = QCNT_W'(Q_DEPTH);

    typedef logic [WORDS-1:0][DATA_W-1:0] words_t;

    typedef struct packed {
        logic [7:0]       src;
        logic [7:0]       dest;
        logic [LEN_W-1:0] len;
        words_t           data;
    } pkt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ASM  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        dest_q, dest_d;
    words_t            asm_data_q, asm_data_d;
    pkt_t              q_mem_q [Q_DEPTH];
    pkt_t              q_mem_d [Q_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [QCNT_W-1:0] q_cnt_q, q_cnt_d;
    logic              drop_err_q, drop_err_d;
    logic [15:0]       sent_cnt_q, sent_cnt_d;

    logic              q_empty;
    logic              q_full;
    logic              pop;
    logic              push;
    logic              beat;
    logic              bad_dest;
    pkt_t              head_pkt;
    pkt_t              push_pkt;
    words_t            beat_words;
    logic [LEN_W-1:0]  beat_len;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(Q_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    always_comb begin
        q_empty   = (q_cnt_q == '0);
        q_full    = (q_cnt_q == Q_DEPTH_L);
        head_pkt  = q_mem_q[rd_ptr_q];
        pop       = ~q_empty & net_accept;
        pkt_valid = pop;
        pkt_out   = q_empty ? '0 : head_pkt;
    end

    // Ready is gated by rst_l so the core sees no acceptance while reset is held.
    always_comb begin
        core_ready = 1'b0;
        if (rst_l) begin
            case (state_q)
                IDLE:    core_ready = ~q_full;
                ASM:     core_ready = ~q_full | pop;
                DROP:    core_ready = 1'b1;
                default: core_ready = 1'b0;
            endcase
        end
    end

    assign beat     = core_valid & core_ready;
    assign bad_dest = ({1'b0, core_dest} >= NODES_LIM) | (core_dest == SELF_ID);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dest_d     = dest_q;
        asm_data_d = asm_data_q;
        drop_err_d = 1'b0;
        push       = 1'b0;
        beat_words = asm_data_q;
        beat_len   = cnt_q + LEN_W'(1);
        for (int i = 0; i < WORDS; i++) begin
            if (cnt_q == LEN_W'(i)) begin
                beat_words[i] = core_data;
            end
        end

        case (state_q)
            IDLE: begin
                if (beat) begin
                    if (bad_dest) begin
                        drop_err_d = 1'b1;
                        if (!core_last) begin
                            state_d = DROP;
                        end
                    end else begin
                        // A fresh packet starts from an all-zero payload so unused slots read 0.
                        beat_words    = '0;
                        beat_words[0] = core_data;
                        beat_len      = LEN_W'(1);
                        dest_d        = core_dest;
                        cnt_d         = beat_len;
                        asm_data_d    = beat_words;
                        if (core_last || (beat_len == WORDS_L)) begin
                            push = 1'b1;
                        end else begin
                            state_d = ASM;
                        end
                    end
                end
            end
            ASM: begin
                if (beat) begin
                    cnt_d      = beat_len;
                    asm_data_d = beat_words;
                    if (core_last || (beat_len == WORDS_L)) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (beat && core_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        push_pkt.src  = SELF_ID;
        push_pkt.dest = dest_d;
        push_pkt.len  = beat_len;
        push_pkt.data = beat_words;
    end

    always_comb begin
        q_mem_d    = q_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        q_cnt_d    = q_cnt_q;
        sent_cnt_d = sent_cnt_q;
        if (push) begin
            q_mem_d[wr_ptr_q] = push_pkt;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d   = ptr_inc(rd_ptr_q);
            sent_cnt_d = sent_cnt_q + 16'd1;
        end
        case ({push, pop})
            2'b10:   q_cnt_d = q_cnt_q + QCNT_W'(1);
            2'b01:   q_cnt_d = q_cnt_q - QCNT_W'(1);
            default: q_cnt_d = q_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dest_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            q_cnt_q    <= '0;
            drop_err_q <= 1'b0;
            sent_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dest_q     <= dest_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            q_cnt_q    <= q_cnt_d;
            drop_err_q <= drop_err_d;
            sent_cnt_q <= sent_cnt_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by the queue count alone.
    always_ff @(posedge clk) begin
        asm_data_q <= asm_data_d;
        for (int i = 0; i < Q_DEPTH; i++) begin
            q_mem_q[i] <= q_mem_d[i];
        end
    end

    assign drop_err = drop_err_q;
    assign sent_cnt = sent_cnt_q;

endmodule

// File: tb/tb_net_injector.sv
// Bench for net_injector: directed scenarios plus a randomized beat stream checked
// against a packet-level model of assembly, dropping and FIFO delivery.
module tb_net_injector;

    localparam int NODE  = 2;
    localparam int NN    = 8;
    localparam int DW    = 64;
    localparam int WORDS = 8;
    localparam int QD    = 2;
    localparam int LEN_W = $clog2(WORDS + 1);
    localparam int PKT_W = 16 + LEN_W + WORDS * DW;

    typedef logic [DW-1:0] word_t;

    logic             clk = 1'b0;
    logic             rst_l;
    logic             core_valid;
    logic             core_ready;
    logic [7:0]       core_dest;
    logic [DW-1:0]    core_data;
    logic             core_last;
    logic             net_accept;
    logic             pkt_valid;
    logic [PKT_W-1:0] pkt_out;
    logic             drop_err;
    logic [15:0]      sent_cnt;

    int checks   = 0;
    int errors   = 0;
    int exp_sent = 0;
    int tmo      = 0;
    int coll_cyc = 0;
    logic [PKT_W-1:0] got_q[$];

    net_injector #(
        .NODE_ID(NODE), .NUM_NODES(NN), .DATA_W(DW), .WORDS(WORDS), .Q_DEPTH(QD)
    ) dut (
        .clk(clk), .rst_l(rst_l),
        .core_valid(core_valid), .core_ready(core_ready), .core_dest(core_dest),
        .core_data(core_data), .core_last(core_last),
        .net_accept(net_accept), .pkt_valid(pkt_valid), .pkt_out(pkt_out),
        .drop_err(drop_err), .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [PKT_W-1:0] mk_pkt(input logic [7:0] dest, input word_t w [WORDS], input int n);
        logic [PKT_W-1:0] p;
        p = '0;
        p[PKT_W-1 -: 8]       = 8'(NODE);
        p[PKT_W-9 -: 8]       = dest;
        p[WORDS*DW +: LEN_W]  = LEN_W'(n);
        for (int i = 0; i < n; i++) p[i*DW +: DW] = w[i];
        return p;
    endfunction

    function automatic logic [PKT_W-1:0] mk1(input logic [7:0] dest, input word_t w0);
        word_t w [WORDS];
        for (int i = 0; i < WORDS; i++) w[i] = '0;
        w[0] = w0;
        return mk_pkt(dest, w, 1);
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the beat was taken.
    task automatic send_beat(input logic [7:0] d, input word_t w, input logic l, output int wt);
        core_valid = 1'b1; core_dest = d; core_data = w; core_last = l; wt = 0;
        @(negedge clk);
        while (!core_ready && wt < 100) begin
            wt++;
            @(negedge clk);
        end
        if (!core_ready) tmo++;
        @(posedge clk); #1;
        core_valid = 1'b0; core_last = 1'b0;
    endtask

    // Records packets strobed out until n are seen; also completes a pending core beat.
    task automatic collect_pops(input int n);
        logic took;
        got_q.delete();
        coll_cyc = 0;
        while (coll_cyc < 40 && got_q.size() < n) begin
            @(negedge clk);
            if (pkt_valid) got_q.push_back(pkt_out);
            took = core_valid & core_ready;
            @(posedge clk); #1;
            if (took) begin core_valid = 1'b0; core_last = 1'b0; end
            coll_cyc++;
        end
    endtask

    task automatic test_reset();
        rst_l = 1'b0; core_valid = 1'b0; core_dest = '0; core_data = '0; core_last = 1'b0; net_accept = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (core_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", core_ready); end
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL rst_pkt_valid got %b want 0", pkt_valid); end
        checks++; if (pkt_out !== '0) begin errors++; $display("FAIL rst_pkt_out got %h want 0", pkt_out); end
        checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL rst_drop_err got %b want 0", drop_err); end
        checks++; if (sent_cnt !== 16'd0) begin errors++; $display("FAIL rst_sent_cnt got %0d want 0", sent_cnt); end
        rst_l = 1'b1;
        exp_sent = 0;
        @(negedge clk);
        checks++; if (core_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b want 1", core_ready); end
    endtask

    task automatic test_single();
        int wt;
        word_t w [WORDS];
        logic [PKT_W-1:0] e;
        for (int i = 0; i < WORDS; i++) w[i] = '0;
        w[0] = 64'hA; w[1] = 64'hB; w[2] = 64'hC;
        e = mk_pkt(8'd5, w, 3);
        @(posedge clk); #1;
        net_accept = 1'b1;
        send_beat(8'd5, 64'hA, 1'b0, wt);
        send_beat(8'd5, 64'hB, 1'b0, wt);
        send_beat(8'd5, 64'hC, 1'b1, wt);
        @(negedge clk);
        checks++; if (pkt_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", pkt_valid); end
        checks++; if (pkt_out !== e) begin errors++; $display("FAIL single_pkt got %h want %h", pkt_out, e); end
        @(posedge clk); #1;
        exp_sent++;
        @(negedge clk);
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL single_strobe_len got %b want 0", pkt_valid); end
        checks++; if (pkt_out !== '0) begin errors++; $display("FAIL single_empty_out got %h want 0", pkt_out); end
        checks++; if (sent_cnt !== 16'(exp_sent)) begin errors++; $display("FAIL single_sent got %0d want %0d", sent_cnt, exp_sent); end
        net_accept = 1'b0;
    endtask

    task automatic test_max_len();
        int wt;
        word_t w [WORDS];
        logic [PKT_W-1:0] pa, pb;
        @(posedge clk); #1;
        net_accept = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            w[i] = 64'h100 + 64'(i);
            send_beat(8'd3, w[i], 1'b0, wt);
        end
        pa = mk_pkt(8'd3, w, 8);
        for (int i = 0; i < WORDS; i++) w[i] = '0;
        w[0] = 64'h900; w[1] = 64'h901;
        pb = mk_pkt(8'd6, w, 2);
        @(negedge clk);
        checks++; if (pkt_out !== pa) begin errors++; $display("FAIL maxlen_head got %h want %h", pkt_out, pa); end
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL maxlen_held got %b want 0", pkt_valid); end
        @(posedge clk); #1;
        send_beat(8'd6, 64'h900, 1'b0, wt);
        send_beat(8'd0, 64'h901, 1'b1, wt);
        net_accept = 1'b1;
        collect_pops(2);
        net_accept = 1'b0;
        exp_sent += 2;
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL maxlen_count got %0d want 2", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== pa) begin errors++; $display("FAIL maxlen_pkt8 got %h want %h", got_q[0], pa); end
            checks++; if (got_q[1] !== pb) begin errors++; $display("FAIL maxlen_next got %h want %h", got_q[1], pb); end
        end
        @(negedge clk);
        checks++; if (sent_cnt !== 16'(exp_sent)) begin errors++; $display("FAIL maxlen_sent got %0d want %0d", sent_cnt, exp_sent); end
    endtask

    task automatic test_drop();
        int wt, nd, nv, nr;
        logic [7:0] dl [4];
        logic [PKT_W-1:0] e;
        dl[0] = 8'd2; dl[1] = 8'd5; dl[2] = 8'd5; dl[3] = 8'd9;
        nd = 0; nv = 0; nr = 0;
        @(posedge clk); #1;
        net_accept = 1'b1;
        for (int i = 0; i < 4; i++) begin
            core_valid = 1'b1; core_dest = dl[i]; core_data = 64'(i); core_last = (i >= 2);
            @(negedge clk);
            if (!core_ready) nr++;
            if (drop_err) nd++;
            if (pkt_valid) nv++;
            @(posedge clk); #1;
        end
        core_valid = 1'b0; core_last = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (drop_err) nd++;
            if (pkt_valid) nv++;
            @(posedge clk); #1;
        end
        checks++; if (nr != 0) begin errors++; $display("FAIL drop_ready_low got %0d want 0", nr); end
        checks++; if (nd != 2) begin errors++; $display("FAIL drop_pulses got %0d want 2", nd); end
        checks++; if (nv != 0) begin errors++; $display("FAIL drop_queued got %0d want 0", nv); end
        e = mk1(8'd4, 64'h77);
        send_beat(8'd4, 64'h77, 1'b1, wt);
        @(negedge clk);
        checks++; if (pkt_valid !== 1'b1 || pkt_out !== e) begin errors++; $display("FAIL drop_recover got %b/%h want 1/%h", pkt_valid, pkt_out, e); end
        @(posedge clk); #1;
        exp_sent++;
        net_accept = 1'b0;
        @(negedge clk);
        checks++; if (sent_cnt !== 16'(exp_sent)) begin errors++; $display("FAIL drop_sent got %0d want %0d", sent_cnt, exp_sent); end
    endtask

    task automatic test_backpressure();
        int wt;
        logic [PKT_W-1:0] p [3];
        p[0] = mk1(8'd1, 64'h31); p[1] = mk1(8'd4, 64'h32); p[2] = mk1(8'd6, 64'h33);
        @(posedge clk); #1;
        net_accept = 1'b0;
        send_beat(8'd1, 64'h31, 1'b1, wt);
        checks++; if (wt != 0) begin errors++; $display("FAIL bp_first_wait got %0d want 0", wt); end
        send_beat(8'd4, 64'h32, 1'b1, wt);
        checks++; if (wt != 0) begin errors++; $display("FAIL bp_second_wait got %0d want 0", wt); end
        core_valid = 1'b1; core_dest = 8'd6; core_data = 64'h33; core_last = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++; if (core_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", core_ready); end
            checks++; if (pkt_valid !== 1'b0 || pkt_out !== p[0]) begin errors++; $display("FAIL bp_hold got %b/%h want 0/%h", pkt_valid, pkt_out, p[0]); end
            @(posedge clk); #1;
        end
        net_accept = 1'b1;
        collect_pops(3);
        net_accept = 1'b0;
        exp_sent += 3;
        checks++; if (got_q.size() != 3 || coll_cyc != 3) begin errors++; $display("FAIL bp_drain got %0d pkts in %0d cycles want 3 in 3", got_q.size(), coll_cyc); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== p[i]) begin errors++; $display("FAIL bp_order%0d got %h want %h", i, got_q[i], p[i]); end
        end
        @(negedge clk);
        checks++; if (sent_cnt !== 16'(exp_sent)) begin errors++; $display("FAIL bp_sent got %0d want %0d", sent_cnt, exp_sent); end
    endtask

    task automatic test_simul_push_pop();
        int wt;
        word_t w [WORDS];
        logic [PKT_W-1:0] p1, p2, p3, p4;
        for (int i = 0; i < WORDS; i++) w[i] = '0;
        w[0] = 64'h51; w[1] = 64'h52;
        p1 = mk1(8'd1, 64'h41); p2 = mk_pkt(8'd5, w, 2);
        p3 = mk1(8'd3, 64'h61); p4 = mk1(8'd7, 64'h71);
        @(posedge clk); #1;
        net_accept = 1'b0;
        send_beat(8'd1, 64'h41, 1'b1, wt);
        send_beat(8'd5, 64'h51, 1'b0, wt);
        core_valid = 1'b1; core_dest = 8'd5; core_data = 64'h52; core_last = 1'b1; net_accept = 1'b1;
        @(negedge clk);
        checks++; if (pkt_valid !== 1'b1 || pkt_out !== p1) begin errors++; $display("FAIL pp_pop got %b/%h want 1/%h", pkt_valid, pkt_out, p1); end
        checks++; if (core_ready !== 1'b1) begin errors++; $display("FAIL pp_ready got %b want 1", core_ready); end
        @(posedge clk); #1;
        core_valid = 1'b0; core_last = 1'b0; net_accept = 1'b0;
        exp_sent++;
        @(negedge clk);
        checks++; if (pkt_out !== p2) begin errors++; $display("FAIL pp_head got %h want %h", pkt_out, p2); end
        @(posedge clk); #1;
        send_beat(8'd3, 64'h61, 1'b1, wt);
        checks++; if (wt != 0) begin errors++; $display("FAIL pp_space got wait %0d want 0", wt); end
        core_valid = 1'b1; core_dest = 8'd7; core_data = 64'h71; core_last = 1'b1;
        @(negedge clk);
        checks++; if (core_ready !== 1'b0) begin errors++; $display("FAIL pp_full got %b want 0", core_ready); end
        @(posedge clk); #1;
        net_accept = 1'b1;
        collect_pops(3);
        net_accept = 1'b0;
        exp_sent += 3;
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL pp_count got %0d want 3", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== p2 || got_q[1] !== p3 || got_q[2] !== p4) begin
                errors++; $display("FAIL pp_order got dests %h %h %h want 05 03 07",
                    got_q[0][PKT_W-9 -: 8], got_q[1][PKT_W-9 -: 8], got_q[2][PKT_W-9 -: 8]);
            end
        end
        @(negedge clk);
        checks++; if (sent_cnt !== 16'(exp_sent)) begin errors++; $display("FAIL pp_sent got %0d want %0d", sent_cnt, exp_sent); end
    endtask

    task automatic test_reset_mid();
        int wt, nv;
        logic [PKT_W-1:0] e;
        @(posedge clk); #1;
        net_accept = 1'b0;
        send_beat(8'd1, 64'h81, 1'b1, wt);
        send_beat(8'd4, 64'h82, 1'b0, wt);
        send_beat(8'd4, 64'h83, 1'b0, wt);
        #2;
        rst_l = 1'b0; net_accept = 1'b1;
        #1;
        checks++; if (core_ready !== 1'b0) begin errors++; $display("FAIL mrst_ready got %b want 0", core_ready); end
        checks++; if (pkt_valid !== 1'b0 || pkt_out !== '0) begin errors++; $display("FAIL mrst_pkt got %b/%h want 0/0", pkt_valid, pkt_out); end
        checks++; if (sent_cnt !== 16'd0 || drop_err !== 1'b0) begin errors++; $display("FAIL mrst_cnt got %0d/%b want 0/0", sent_cnt, drop_err); end
        exp_sent = 0;
        @(negedge clk);
        rst_l = 1'b1;
        nv = 0;
        repeat (3) begin
            @(negedge clk);
            if (pkt_valid) nv++;
        end
        checks++; if (nv != 0) begin errors++; $display("FAIL mrst_stale got %0d strobes want 0", nv); end
        e = mk1(8'd4, 64'h84);
        @(posedge clk); #1;
        send_beat(8'd4, 64'h84, 1'b1, wt);
        @(negedge clk);
        checks++; if (pkt_valid !== 1'b1 || pkt_out !== e) begin errors++; $display("FAIL mrst_fresh got %b/%h want 1/%h", pkt_valid, pkt_out, e); end
        @(posedge clk); #1;
        exp_sent++;
        net_accept = 1'b0;
        @(negedge clk);
        checks++; if (sent_cnt !== 16'(exp_sent)) begin errors++; $display("FAIL mrst_sent got %0d want %0d", sent_cnt, exp_sent); end
    endtask

    task automatic test_random();
        logic [7:0] bd[$];
        word_t      bw[$];
        logic       bl[$];
        logic [PKT_W-1:0] exp_pk[$];
        int exp_drops, ndrop, wt;
        bit done;
        word_t cw [WORDS];
        int cn;
        logic [7:0] cd;
        bit in_pkt, dropping;

        for (int p = 0; p < 30; p++) begin
            logic [7:0] d;
            int n;
            d = 8'($urandom_range(0, 9));
            n = $urandom_range(1, 10);
            for (int b = 0; b < n; b++) begin
                bd.push_back(d);
                bw.push_back({$urandom(), $urandom()});
                bl.push_back(b == n - 1);
            end
        end

        // Model: a packet opens on a valid first beat and closes on last or at WORDS beats.
        exp_drops = 0; in_pkt = 0; dropping = 0; cn = 0; cd = '0;
        for (int i = 0; i < bd.size(); i++) begin
            if (dropping) begin
                if (bl[i]) dropping = 0;
                continue;
            end
            if (!in_pkt) begin
                if (bd[i] >= NN || bd[i] == NODE) begin
                    exp_drops++;
                    if (!bl[i]) dropping = 1;
                    continue;
                end
                in_pkt = 1; cd = bd[i]; cn = 0;
                for (int k = 0; k < WORDS; k++) cw[k] = '0;
            end
            cw[cn] = bw[i];
            cn++;
            if (bl[i] || cn == WORDS) begin
                exp_pk.push_back(mk_pkt(cd, cw, cn));
                in_pkt = 0;
            end
        end

        ndrop = 0; done = 0; tmo = 0;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < bd.size(); i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send_beat(bd[i], bw[i], bl[i], wt);
                end
                done = 1;
            end
            begin
                int cyc, tail;
                logic [PKT_W-1:0] e;
                cyc = 0; tail = 0;
                while (cyc < 4000 && !(done && exp_pk.size() == 0 && tail >= 3)) begin
                    @(negedge clk);
                    if (drop_err) ndrop++;
                    if (pkt_valid) begin
                        checks++;
                        if (exp_pk.size() == 0) begin
                            errors++; $display("FAIL rnd_extra got %h want no packet", pkt_out);
                        end else begin
                            e = exp_pk.pop_front();
                            exp_sent++;
                            if (pkt_out !== e) begin errors++; $display("FAIL rnd_pkt got %h want %h", pkt_out, e); end
                        end
                    end
                    if (done) tail++;
                    @(posedge clk); #1;
                    net_accept = ($urandom_range(0, 3) != 0);
                    cyc++;
                end
                checks++; if (cyc >= 4000) begin errors++; $display("FAIL rnd_timeout got %0d cycles want <4000", cyc); end
            end
        join
        net_accept = 1'b0;
        @(negedge clk);
        checks++; if (ndrop != exp_drops) begin errors++; $display("FAIL rnd_drops got %0d want %0d", ndrop, exp_drops); end
        checks++; if (exp_pk.size() != 0) begin errors++; $display("FAIL rnd_missing got %0d left want 0", exp_pk.size()); end
        checks++; if (sent_cnt !== 16'(exp_sent)) begin errors++; $display("FAIL rnd_sent got %0d want %0d", sent_cnt, exp_sent); end
        checks++; if (tmo != 0) begin errors++; $display("FAIL rnd_ready_timeout got %0d want 0", tmo); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_max_len();
        test_drop();
        test_backpressure();
        test_simul_push_pop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
